uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte producers using round-robin arbitration.
- Sequences the uart_tx write_en/data_ready handshake so that exactly one byte is issued per frame.
- Owns the baud clock_divider configuration and applies updates only between frames.
- Sits between CPU/peripheral byte sources and the uart_tx instance in grok80.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data bits per frame; matches uart_tx WIDTH.
- DIVIDER_RESET, 16'h0001, clock_divider value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte; held until acked.
- req_data  in  NUM_REQ*WIDTH  byte of requester i at bits [i*WIDTH +: WIDTH]; stable while valid.
- req_ack  out  NUM_REQ  one-cycle pulse: requester i's byte was issued to uart_tx.
- cfg_divider  in  16  new baud divider.
- cfg_divider_we  in  1  one-cycle write strobe for cfg_divider.
- uart_data_ready  in  1  uart_tx data_ready.
- uart_write_en  out  1  to uart_tx write_en.
- uart_data_in  out  WIDTH  to uart_tx data_in.
- uart_clock_divider  out  16  to uart_tx clock_divider.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the last granted requester.

Behaviour:
- Reset values:
  - state=IDLE; req_ack=0; uart_write_en=0; uart_data_in=0; uart_clock_divider=DIVIDER_RESET; busy=0.
  - grant_id=NUM_REQ-1, so requester 0 has first priority; divider_pending=0.
- Reset is asynchronous on the falling edge of reset_n, including mid-frame. uart_write_en drops immediately; the partial frame belongs to uart_tx.
- IDLE:
  - If divider_pending: load uart_clock_divider from the pending register, clear pending, stay in IDLE one cycle. No grant is made that cycle.
  - Else if uart_data_ready=1 and any req_valid: select the first valid requester searching upward from grant_id+1 (mod NUM_REQ). Register grant_id and uart_data_in, then go to ISSUE.
  - Else stay in IDLE. uart_data_ready=0 in IDLE (uart still draining) blocks grants.
- ISSUE (exactly 1 cycle):
  - uart_write_en=1; req_ack[grant_id]=1.
  - Next state is WAIT_LOW.
- WAIT_LOW: uart_write_en=0; wait for uart_data_ready=0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for uart_data_ready=1, then go to IDLE.
- Latency and throughput:
  - Grant to uart_write_en is 1 cycle.
  - uart_write_en is never held across a frame boundary, which prevents uart_tx from auto-restarting with stale data.
  - Back-to-back frames have 2 idle cycles after data_ready returns (IDLE decision, then ISSUE).
- Divider writes:
  - cfg_divider_we in any state captures cfg_divider into the pending register and sets divider_pending.
  - A later write before application overwrites the earlier one; the last value wins.
  - A write in the same cycle IDLE applies a previous pending value: the new value stays pending.
- A requester dropping req_valid before ack is legal and simply withdraws. Data sampled at grant is the byte sent.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- With the macro:
  - Adds input req_lock [NUM_REQ].
  - If req_lock[grant_id]=1 in the ISSUE cycle, lock is set. While locked, IDLE grants only grant_id, without rotation, so multi-byte packets are not interleaved.
  - Lock clears when that requester is seen in IDLE with req_valid=0 or req_lock=0; rotation then resumes.
  - Pending divider updates are deferred until the lock clears.
- Without the macro: req_lock is absent; plain round-robin every frame.

Decomposition:
- Package uart_pkg:
  - State enum (IDLE, ISSUE, WAIT_LOW, WAIT_HIGH).
  - DIVIDER_W=16 constant.
  - Shared default divider constant.
- Sub-module rr_arbiter (NUM_REQ): takes request vector and last-grant index, returns one-hot grant plus index. Purely combinational, reusable by other grok80 resource sharers.

Test Plan:
- Reset, then req_valid=4'b0001 with data 8'hAA and uart_data_ready=1 → write_en high exactly 1 cycle; data_in=AA; req_ack=0001; busy=1 until data_ready returns.
- req_valid=4'b1111, data 11/22/33/44 → issue order 11,22,33,44; one write_en pulse per frame; no second pulse while data_ready=0.
- With grant_id=2, req_valid=4'b0101 → requester 0 granted next.
- cfg_divider=16'h0003 written mid-frame → uart_clock_divider stays 0001 until IDLE, then becomes 0003 before the next ISSUE. Two writes (5, then 7) mid-frame → 7 applied.
- Pull reset_n low during WAIT_HIGH → outputs immediately at reset values. After release, a pending request is re-granted once data_ready=1.
- With UART_TX_ARB_LOCK_EN: requester 1 locks and sends 3 bytes while requester 0 is valid → bytes 1,1,1 then 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the grok80 uart_tx arbiter and its helpers.
package uart_pkg;

  localparam int DIVIDER_W = 16;
  localparam logic [DIVIDER_W-1:0] DIVIDER_DEFAULT = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request above last_i, wrapping around.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // The search starts one past the last grant, so last_i itself has lowest priority.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s          = IDX_W'((32'(last_i) + 32'(k)) % 32'(NUM_REQ));
      hit_s           = !any_o && req_i[cand_s];
      grant_o[cand_s] = grant_o[cand_s] | hit_s;
      grant_idx_o     = hit_s ? cand_s : grant_idx_o;
      any_o           = any_o | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte producers, one byte per frame.
// Optional packet lock (no interleaving of a locked requester) under UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int                   NUM_REQ       = 4,
  parameter  int                   WIDTH         = 8,
  parameter  logic [DIVIDER_W-1:0] DIVIDER_RESET = DIVIDER_DEFAULT,
  localparam int                   IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [NUM_REQ-1:0]       req_ack,
  input  logic [DIVIDER_W-1:0]     cfg_divider,
  input  logic                     cfg_divider_we,
  input  logic                     uart_data_ready,
  output logic                     uart_write_en,
  output logic [WIDTH-1:0]         uart_data_in,
  output logic [DIVIDER_W-1:0]     uart_clock_divider,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id
);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 we_q;
  logic [WIDTH-1:0]     data_q;
  logic                 busy_q;
  logic [IDX_W-1:0]     grant_q;
  logic [DIVIDER_W-1:0] div_q;
  logic [DIVIDER_W-1:0] pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;

  logic [WIDTH-1:0]     req_bytes_s [NUM_REQ];
  logic [NUM_REQ-1:0]   arb_grant_s;
  logic [IDX_W-1:0]     arb_idx_s;
  logic                 arb_any_s;
  logic                 idle_s;
  logic                 grant_go_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [NUM_REQ-1:0]   sel_onehot_s;
  logic                 div_apply_s;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes_s[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i       (req_valid),
    .last_i      (grant_q),
    .grant_o     (arb_grant_s),
    .grant_idx_o (arb_idx_s),
    .any_o       (arb_any_s)
  );

  assign idle_s = (state_q == ST_IDLE);

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q;
  logic lock_hold_s;

  // While locked, only the locked requester may be granted and divider updates wait.
  always_comb begin
    lock_hold_s = lock_q && req_valid[grant_q] && req_lock[grant_q];
    if (lock_q) begin
      grant_go_s              = idle_s && lock_hold_s && uart_data_ready;
      sel_idx_s               = grant_q;
      sel_onehot_s            = '0;
      sel_onehot_s[grant_q]   = 1'b1;
      div_apply_s             = 1'b0;
    end else begin
      grant_go_s   = idle_s && !pend_q && uart_data_ready && arb_any_s;
      sel_idx_s    = arb_idx_s;
      sel_onehot_s = arb_grant_s;
      div_apply_s  = idle_s && pend_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
    end else if ((state_q == ST_ISSUE) && req_lock[grant_q]) begin
      lock_q <= 1'b1;
    end else if (idle_s && lock_q && !lock_hold_s) begin
      lock_q <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_go_s   = idle_s && !pend_q && uart_data_ready && arb_any_s;
    sel_idx_s    = arb_idx_s;
    sel_onehot_s = arb_grant_s;
    div_apply_s  = idle_s && pend_q;
  end
`endif

  // A write landing on the apply cycle stays pending; the older value goes out first.
  always_comb begin
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (cfg_divider_we) begin
      pend_d     = 1'b1;
      pend_val_d = cfg_divider;
    end else if (div_apply_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      pend_val_q <= DIVIDER_RESET;
      div_q      <= DIVIDER_RESET;
    end else begin
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      if (div_apply_s) begin
        div_q <= pend_val_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_go_s) begin
            state_q <= ST_ISSUE;
            grant_q <= sel_idx_s;
            data_q  <= req_bytes_s[sel_idx_s];
            ack_q   <= sel_onehot_s;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_LOW;
          ack_q   <= '0;
          we_q    <= 1'b0;
        end
        ST_WAIT_LOW: begin
          if (!uart_data_ready) begin
            state_q <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (uart_data_ready) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= '0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack            = ack_q;
  assign uart_write_en      = we_q;
  assign uart_data_in       = data_q;
  assign uart_clock_divider = div_q;
  assign busy               = busy_q;
  assign grant_id           = grant_q;

endmodule
